// File: rtl/vx_barrier_unit_if.sv
// Barrier arrival bus from the warp-control stage and release/stall outputs
// toward the warp scheduler.
interface vx_barrier_unit_if #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4
);
    localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    logic                 bar_valid;
    logic [NW_WIDTH-1:0]  bar_wid;
    logic [NB_WIDTH-1:0]  bar_id;
    logic [NW_WIDTH-1:0]  bar_size_m1;
    logic [NUM_WARPS-1:0] stalled_warps;
    logic                 release_valid;
    logic [NB_WIDTH-1:0]  release_id;
    logic [NUM_WARPS-1:0] release_mask;

    modport master (
        output bar_valid, bar_wid, bar_id, bar_size_m1,
        input  stalled_warps, release_valid, release_id, release_mask
    );

    modport slave (
        input  bar_valid, bar_wid, bar_id, bar_size_m1,
        output stalled_warps, release_valid, release_id, release_mask
    );
endinterface

// File: rtl/vx_barrier_unit.sv
// Per-core local barrier tracker: counts arrivals per slot, stalls waiting
// warps and releases all participants with a one-cycle pulse on completion.
module vx_barrier_unit #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4
) (
    input  logic              clk,
    input  logic              reset,
    vx_barrier_unit_if.slave  bar
);
    localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    logic [NW_WIDTH-1:0]     count_reg [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]     size_reg  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    wmask_reg [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] busy_reg;

    logic [NUM_WARPS-1:0]    stalled_reg;
    logic                    rel_valid_reg;
    logic [NB_WIDTH-1:0]     rel_id_reg;
    logic [NUM_WARPS-1:0]    rel_mask_reg;

    logic [NUM_WARPS-1:0]    wid_onehot;
    logic [NUM_WARPS-1:0]    sel_wmask;
    logic [NW_WIDTH-1:0]     sel_count;
    logic [NW_WIDTH-1:0]     eff_size;
    logic                    arrive;
    logic                    complete;
    logic [NUM_BARRIERS-1:0] slot_hit;

    // An idle slot uses the incoming size; a busy slot keeps its latched one.
    always_comb begin
        wid_onehot = NUM_WARPS'(1) << bar.bar_wid;
        sel_wmask  = wmask_reg[bar.bar_id];
        sel_count  = count_reg[bar.bar_id];
        eff_size   = busy_reg[bar.bar_id] ? size_reg[bar.bar_id] : bar.bar_size_m1;
        arrive     = bar.bar_valid && ((sel_wmask & wid_onehot) == '0);
        complete   = arrive && (sel_count == eff_size);
    end

    generate
        for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_slot_hit
            assign slot_hit[gi] = arrive && (bar.bar_id == NB_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                count_reg[b] <= '0;
                size_reg[b]  <= '0;
                wmask_reg[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                if (slot_hit[b]) begin
                    if (!busy_reg[b]) begin
                        size_reg[b] <= bar.bar_size_m1;
                    end
                    if (complete) begin
                        count_reg[b] <= '0;
                        wmask_reg[b] <= '0;
                        busy_reg[b]  <= 1'b0;
                    end else begin
                        count_reg[b] <= count_reg[b] + NW_WIDTH'(1);
                        wmask_reg[b] <= wmask_reg[b] | wid_onehot;
                        busy_reg[b]  <= 1'b1;
                    end
                end
            end
        end
    end

    // The last arriver is released in the same cycle, so it never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            stalled_reg   <= '0;
            rel_valid_reg <= 1'b0;
            rel_id_reg    <= '0;
            rel_mask_reg  <= '0;
        end else begin
            rel_valid_reg <= complete;
            rel_id_reg    <= complete ? bar.bar_id : '0;
            rel_mask_reg  <= complete ? (sel_wmask | wid_onehot) : '0;
            if (complete) begin
                stalled_reg <= stalled_reg & ~sel_wmask;
            end else if (arrive) begin
                stalled_reg <= stalled_reg | wid_onehot;
            end
        end
    end

    assign bar.stalled_warps = stalled_reg;
    assign bar.release_valid = rel_valid_reg;
    assign bar.release_id    = rel_id_reg;
    assign bar.release_mask  = rel_mask_reg;
endmodule
